// File: rtl/ram_arb.sv
// ram_arb -- single-port RAM shared by two requesters, with power-on clear.
//
// Purpose:
//   WORDS x WIDTH storage, one access per cycle. After reset a sequencer
//   writes zero to every word (busy=1). After that a two-port arbiter
//   grants port A or port B each ce-high cycle. Reads have one cycle of
//   latency and give a one-cycle valid pulse. Addresses >= WORDS are
//   granted: writes to them are dropped and reads of them return zero.
//
// Configuration macro:
//   RAM_ARB_RR_EN  defined   -> round-robin arbitration (1-bit favour pointer)
//                  undefined -> fixed priority, A wins contention
//
// Ports:
//   clk, reset (async, active-high), ce (clock enable), busy (clear running)
//   x_req, x_addr, x_write, x_d_in  : request side, x = a | b
//   x_gnt (combinational), x_valid, x_d_out (registered) : response side
module ram_arb #(
   parameter int WORDS = 512,
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ce,
   output logic                      busy,
   input  logic                      a_req,
   input  logic [$clog2(WORDS)-1:0]  a_addr,
   input  logic                      a_write,
   input  logic [WIDTH-1:0]          a_d_in,
   output logic                      a_gnt,
   output logic                      a_valid,
   output logic [WIDTH-1:0]          a_d_out,
   input  logic                      b_req,
   input  logic [$clog2(WORDS)-1:0]  b_addr,
   input  logic                      b_write,
   input  logic [WIDTH-1:0]          b_d_in,
   output logic                      b_gnt,
   output logic                      b_valid,
   output logic [WIDTH-1:0]          b_d_out
);

   localparam int            D       = $clog2(WORDS);
   localparam logic [D:0]    WORDS_L = (D+1)'(WORDS);
   localparam logic [D-1:0]  LAST    = D'(WORDS - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [WIDTH-1:0] mem [WORDS];

   logic [0:0]       state_q, state_d;
   logic [D-1:0]     clr_q, clr_d;
   logic             a_valid_q, a_valid_d, b_valid_q, b_valid_d;
   logic [WIDTH-1:0] a_d_out_q, a_d_out_d, b_d_out_q, b_d_out_d;

   logic             run;
   logic             a_in, b_in;
   logic             wr_en;
   logic [D-1:0]     wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [D-1:0]     rd_addr;
   logic             rd_in;
   logic [WIDTH-1:0] rd_data;

   // Grants look only at req, ce and state so no address/data path reaches gnt.
   assign run = (state_q == ST_RUN) && ce;

`ifdef RAM_ARB_RR_EN
   logic rr_q, rr_d;   // 0 favours A, 1 favours B on the next contested cycle

   assign a_gnt = run & a_req & (~b_req | ~rr_q);
   assign b_gnt = run & b_req & (~a_req |  rr_q);

   // Only contested grants move the pointer, always to the loser.
   always_comb begin
      rr_d = rr_q;
      if (a_gnt && b_req)      rr_d = 1'b1;
      else if (b_gnt && a_req) rr_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_q <= 1'b0;
      else       rr_q <= rr_d;
   end
`else
   assign a_gnt = run & a_req;
   assign b_gnt = run & b_req & ~a_req;
`endif

   // Range check in D+1 bits so non-power-of-two depths are handled.
   assign a_in = ({1'b0, a_addr} < WORDS_L);
   assign b_in = ({1'b0, b_addr} < WORDS_L);

   assign busy    = (state_q == ST_CLEAR);
   assign a_valid = a_valid_q;
   assign b_valid = b_valid_q;
   assign a_d_out = a_d_out_q;
   assign b_d_out = b_d_out_q;

   // Single write port: the clear sequencer owns it while busy.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (state_q == ST_CLEAR) begin
         wr_en   = ce;
         wr_addr = clr_q;
      end else if (a_gnt && a_write && a_in) begin
         wr_en   = 1'b1;
         wr_addr = a_addr;
         wr_data = a_d_in;
      end else if (b_gnt && b_write && b_in) begin
         wr_en   = 1'b1;
         wr_addr = b_addr;
         wr_data = b_d_in;
      end
   end

   // Single read port shared by whichever side holds the grant.
   assign rd_addr = a_gnt ? a_addr : b_addr;
   assign rd_in   = a_gnt ? a_in   : b_in;
   assign rd_data = rd_in ? mem[rd_addr] : '0;

   always_comb begin
      state_d   = state_q;
      clr_d     = clr_q;
      a_valid_d = a_gnt & ~a_write;
      b_valid_d = b_gnt & ~b_write;
      a_d_out_d = a_valid_d ? rd_data : a_d_out_q;
      b_d_out_d = b_valid_d ? rd_data : b_d_out_q;
      if (state_q == ST_CLEAR && ce) begin
         if (clr_q == LAST) state_d = ST_RUN;
         else               clr_d   = clr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_q     <= '0;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         a_d_out_q <= '0;
         b_d_out_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_q     <= clr_d;
         a_valid_q <= a_valid_d;
         b_valid_q <= b_valid_d;
         a_d_out_q <= a_d_out_d;
         b_d_out_q <= b_d_out_d;
      end
   end

   // Array has no reset; the clear sequencer zeroes it after every reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

   localparam int WORDS = 80;
   localparam int WIDTH = 16;
   localparam int AW    = $clog2(WORDS);

   logic             clk = 1'b0;
   logic             reset, ce, busy;
   logic             a_req, a_write, a_gnt, a_valid;
   logic             b_req, b_write, b_gnt, b_valid;
   logic [AW-1:0]    a_addr, b_addr;
   logic [WIDTH-1:0] a_d_in, a_d_out, b_d_in, b_d_out;

   int passed = 0;
   int total  = 0;

   // Bench-side model state
   logic [WIDTH-1:0] mem_m [WORDS];
   logic [WIDTH-1:0] qa [$];
   logic [WIDTH-1:0] qb [$];
   logic             model_run = 1'b0;
   logic             rr_m = 1'b0;

   ram_arb #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .ce(ce), .busy(busy),
      .a_req(a_req), .a_addr(a_addr), .a_write(a_write), .a_d_in(a_d_in),
      .a_gnt(a_gnt), .a_valid(a_valid), .a_d_out(a_d_out),
      .b_req(b_req), .b_addr(b_addr), .b_write(b_write), .b_d_in(b_d_in),
      .b_gnt(b_gnt), .b_valid(b_valid), .b_d_out(b_d_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   // Read responses: one queue entry pushed at grant must appear as valid
   // data exactly at the next negative edge.
   always @(negedge clk) begin
      logic [WIDTH-1:0] e;
      chk("a_valid", a_valid, qa.size() != 0);
      if (qa.size() != 0) begin
         e = qa.pop_front();
         chk("a_d_out", a_d_out, e);
      end
      chk("b_valid", b_valid, qb.size() != 0);
      if (qb.size() != 0) begin
         e = qb.pop_front();
         chk("b_d_out", b_d_out, e);
      end
   end

   // Check grants/busy for the current cycle and update the model.
   task automatic eval();
      logic run, ea, eb;
      @(negedge clk); #2;
      run = model_run && ce;
      ea  = run && a_req && (!b_req || !rr_m);
      eb  = run && b_req && (!a_req ||  rr_m);
      chk("a_gnt", a_gnt, ea);
      chk("b_gnt", b_gnt, eb);
      chk("busy", busy, !model_run);
      if (ea) begin
         if (a_write) begin
            if (int'(a_addr) < WORDS) mem_m[int'(a_addr)] = a_d_in;
         end else qa.push_back(int'(a_addr) < WORDS ? mem_m[int'(a_addr)] : '0);
      end
      if (eb) begin
         if (b_write) begin
            if (int'(b_addr) < WORDS) mem_m[int'(b_addr)] = b_d_in;
         end else qb.push_back(int'(b_addr) < WORDS ? mem_m[int'(b_addr)] : '0);
      end
`ifdef RAM_ARB_RR_EN
      if (ea && b_req)      rr_m = 1'b1;
      else if (eb && a_req) rr_m = 1'b0;
`endif
   endtask

   task automatic adv();
      @(posedge clk); #1;
   endtask

   task automatic step();
      eval();
      adv();
   endtask

   // Count busy cycles after reset release; requests are held high to
   // confirm nothing is granted during the clear.
   task automatic clear_wait();
      int cnt = 0;
      int g   = 0;
      while (busy && cnt < 2 * WORDS) begin
         @(negedge clk);
         if (a_gnt || b_gnt) g++;
         adv();
         cnt++;
      end
      chk("clear_len", cnt, WORDS);
      chk("clear_gnt", g, 0);
      for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
      model_run = 1'b1;
      rr_m      = 1'b0;
   endtask

   task automatic idle();
      a_req = 1'b0; b_req = 1'b0; a_write = 1'b0; b_write = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] sa, sb;
      reset = 1'b1; ce = 1'b1;
      idle();
      a_addr = '0; b_addr = '0; a_d_in = '0; b_d_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1);
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_a_d_out", a_d_out, 0);
      chk("rst_b_d_out", b_d_out, 0);
      chk("rst_a_valid", a_valid, 0);

      // Clear sequence
      a_req = 1'b1; b_req = 1'b1;
      reset = 1'b0;
      clear_wait();
      idle();

      // Every word reads back zero
      for (int i = 0; i < WORDS; i++) begin
         a_req = 1'b1; a_addr = AW'(i);
         step();
      end
      idle(); step();

      // A writes 0xA5 to 3, B reads 3 next cycle
      a_req = 1'b1; a_write = 1'b1; a_addr = 3; a_d_in = 16'h00A5;
      step();
      idle(); b_req = 1'b1; b_addr = 3;
      step();
      idle(); step();
      chk("basic_b_d_out", b_d_out, 16'h00A5);

      // Preload words 10..13
      for (int i = 10; i < 14; i++) begin
         a_req = 1'b1; a_write = 1'b1; a_addr = AW'(i); a_d_in = 16'h1100 + 16'(i);
         step();
      end
      idle();

      // Contention: both read for 4 cycles, then A drops
      a_req = 1'b1; b_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_addr = AW'(10 + i); b_addr = AW'(13 - i);
         step();
      end
      a_req = 1'b0;
      step();
      idle(); step();

      // Range: write 79, write 80 (dropped), read 80, read 79, B reads 127
      a_req = 1'b1; a_write = 1'b1; a_addr = 79; a_d_in = 16'h1234; step();
      a_addr = 80; a_d_in = 16'hBEEF; step();
      a_write = 1'b0; a_addr = 80; step();
      a_addr = 79; step();
      idle(); b_req = 1'b1; b_addr = 7'd127; step();
      idle(); step();
      chk("range_79", a_d_out, 16'h1234);

      // Write by B then read by A, same address, consecutive cycles
      b_req = 1'b1; b_write = 1'b1; b_addr = 5; b_d_in = 16'h55AA; step();
      idle(); a_req = 1'b1; a_addr = 5; step();
      idle(); step();

      // ce low: no grants, outputs hold
      sa = a_d_out; sb = b_d_out;
      ce = 1'b0; a_req = 1'b1; b_req = 1'b1; a_addr = 79; b_addr = 3;
      repeat (3) step();
      chk("ce0_a_hold", a_d_out, sa);
      chk("ce0_b_hold", b_d_out, sb);
      ce = 1'b1; idle(); step();

      // Reset right after a granted read of word 79
      a_req = 1'b1; a_addr = 79;
      step();
      reset = 1'b1;
      qa.delete(); qb.delete();
      model_run = 1'b0;
      #1;
      chk("mid_a_valid", a_valid, 0);
      chk("mid_a_d_out", a_d_out, 0);
      chk("mid_busy", busy, 1);
      chk("mid_a_gnt", a_gnt, 0);
      repeat (2) adv();
      reset = 1'b0;
      clear_wait();
      idle();
      a_req = 1'b1; a_addr = 79; step();
      a_addr = 3; step();
      idle(); step(); step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ram_arb.md
# ram_arb

Parametrised single-port RAM with a built-in two-requester arbiter and a power-on clear sequencer, for memories shared by two masters (e.g. CPU and DMA/PPU fetch). It generalises the fixed-size single-port RAMs to any depth and width and adds:
- per-port request/grant handshake,
- read-valid strobes,
- out-of-range address handling,
- a guaranteed zeroed array after reset.

## Interface
Parameters:
- WORDS, 512: number of words; need not be a power of two (minimum 2).
- WIDTH, 8: data width in bits.

Ports (D = $clog2(WORDS)):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; gates grants and the clear sequencer.
- busy  out  1  high while the clear sequencer runs.
- a_req  in  1  port A access request.
- a_addr  in  D  port A word address.
- a_write  in  1  port A write (1) / read (0).
- a_d_in  in  WIDTH  port A write data.
- a_gnt  out  1  port A request accepted this cycle (combinational).
- a_valid  out  1  port A read data valid (one-cycle pulse).
- a_d_out  out  WIDTH  port A read data (registered, holds value).
- b_req, b_addr, b_write, b_d_in, b_gnt, b_valid, b_d_out: port B, identical to port A.

## Operation
- Storage: WORDS x WIDTH array; one access per cycle in total.
- FSM states:
  - CLEAR: on reset release, writes 0 to addresses 0..WORDS-1, one per ce-high cycle. busy=1; no grants. After the write to WORDS-1 it moves to RUN.
  - RUN: busy=0; arbiter active. Stays in RUN until reset.
- Grant (RUN, ce=1):
  - Only A requests: a_gnt=1.
  - Only B requests: b_gnt=1.
  - Both request: the priority port is granted; the other sees gnt=0 and must hold req/addr/write/d_in stable until granted.
  - At most one gnt is high in any cycle.
- Priority: fixed, A over B (see Configuration).
- Accepted write: mem[addr] <= d_in at the edge. No valid pulse; d_out unchanged.
- Accepted read: at the edge, that port's d_out <= mem[addr] (pre-write contents) and its valid is set for the next cycle. The other port's d_out holds.
- Out of range (addr >= WORDS):
  - Request is still granted.
  - Write is discarded.
  - Read returns 0 with valid pulse.
- ce=0: no grants; FSM, clear address and round-robin pointer hold; d_out holds; valid deasserts on the next edge.
- Reset, asserted at any time including mid-clear or mid-read:
  - Immediately: busy=1, a_valid=b_valid=0, a_d_out=b_d_out=0, gnt=0.
  - FSM enters CLEAR with clear address 0.
  - Round-robin pointer resets to favour A.
  - An outstanding read is dropped with no valid pulse.

## Timing
- Reset values: busy=1, a_gnt=b_gnt=0, a_valid=b_valid=0, a_d_out=b_d_out=0.
- Clear duration: exactly WORDS ce-high cycles after reset deasserts. busy falls on the edge that writes address WORDS-1.
- First possible grant: the cycle busy is low.
- Read latency: 1 cycle. Request granted in cycle N gives valid=1 and data in cycle N+1.
- Back-to-back: one port may be granted every cycle. Pipelined reads give continuous valid.
- Write then read, same address, consecutive cycles (either port): the read returns the new data.
- gnt depends combinationally on req, ce and state only. No path from addr or d_in to gnt.

## Configuration
- RAM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer names the favoured port for the next contested cycle.
  - After any grant made while both ports requested, the pointer moves to the port not granted.
  - Uncontested grants leave the pointer unchanged.
- RAM_ARB_RR_EN undefined: fixed priority, A always wins contention; pointer logic absent.

## Test plan
- Reset clear, WORDS=16, WIDTH=8: release reset with ce=1 -> busy high for exactly 16 cycles; reads of addresses 0..15 then return 0x00.
- Basic access: A writes 0xA5 to 3; next cycle B reads 3 -> b_gnt=1, then b_valid=1 with b_d_out=0xA5 one cycle later; a_valid stays 0 throughout.
- Contention, macro undefined: A and B both read every cycle for 4 cycles -> a_gnt=1 all 4 cycles, b_gnt=0; B is granted in the first cycle A drops req.
- Contention, RAM_ARB_RR_EN: both read continuously for 4 cycles -> grants alternate A, B, A, B.
- Range and ce, WORDS=80, WIDTH=16: write 0x1234 to 79, write to 80, read 80 -> read returns 0x0000 and 79 still holds 0x1234. ce=0 with req high for 3 cycles -> no gnt, busy/d_out unchanged.
- Reset mid-operation: assert reset in the cycle after a granted read -> valid never pulses, d_out=0 immediately, busy=1, clear restarts at address 0 and lasts the full WORDS cycles.
